// File: rtl/html_char_streamer_if.sv
// html_char_streamer_if
//   Bundles the streamer's control inputs, ROM read port and parser-facing
//   outputs. The streamer uses the slave modport; whatever drives it
//   (frame controller + ROM + parser) uses the master modport.
//   Signals:
//     start, frame_start, pause   control in
//     mem_addr / mem_rdata        synchronous ROM read port (1-cycle latency)
//     char, state_enable          character and enable to the parser
//     busy, done, char_count      status
interface html_char_streamer_if #(
  parameter int ADDR_W = 12,
  parameter int CHAR_W = 8
);
  logic              start;
  logic              frame_start;
  logic              pause;
  logic [ADDR_W-1:0] mem_addr;
  logic [CHAR_W-1:0] mem_rdata;
  logic [CHAR_W-1:0] char;
  logic              state_enable;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   char_count;

  modport slave (
    input  start, frame_start, pause, mem_rdata,
    output mem_addr, char, state_enable, busy, done, char_count
  );

  modport master (
    output start, frame_start, pause, mem_rdata,
    input  mem_addr, char, state_enable, busy, done, char_count
  );
endinterface

// File: rtl/html_char_streamer.sv
// html_char_streamer
//   Reads a NUL-terminated document from a synchronous character ROM and
//   feeds it one character per cycle to the HTML parser, stalling while the
//   parser asserts pause. After the terminator (or the last addressable
//   character) the pass drains for DRAIN_CYCLES unpaused cycles with
//   state_enable still high, then drops state_enable so the parser clears.
//   Ports:
//     clock, resetn   clock and asynchronous active-low reset
//     bus (slave)     start/frame_start/pause in, ROM port, char,
//                     state_enable, busy, done, char_count out
//   Build option:
//     HTML_STREAM_AUTOREPLAY_EN - in DONE, frame_start restarts the pass.
module html_char_streamer #(
  parameter int ADDR_W       = 12,
  parameter int CHAR_W       = 8,
  parameter int DOC_LEN      = 4096,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  html_char_streamer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DOC_LEN - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DW-1:0]     r_drain;

  logic w_stream, w_nul, w_last, w_advance, w_restart;

  assign w_stream  = (r_state == S_STREAM);
  assign w_nul     = (bus.mem_rdata == '0);
  assign w_last    = (r_ptr == LAST_ADDR);
  assign w_advance = w_stream && !bus.pause && !w_nul && !w_last;

`ifdef HTML_STREAM_AUTOREPLAY_EN
  // frame_start only counts in DONE, so done is always seen for >=1 cycle.
  assign w_restart = bus.start || ((r_state == S_DONE) && bus.frame_start);
`else
  logic w_unused;
  assign w_unused  = bus.frame_start;
  assign w_restart = bus.start;
`endif

  // Look one address ahead on an advancing edge so the ROM's one-cycle
  // latency is hidden and a new character appears every unpaused cycle.
  assign bus.mem_addr     = !w_stream ? '0 : (w_advance ? r_ptr + 1'b1 : r_ptr);
  assign bus.char         = w_stream ? bus.mem_rdata : '0;
  // Decoded straight from the state register so they drop with the async reset.
  assign bus.state_enable = w_stream || (r_state == S_DRAIN);
  assign bus.busy         = (r_state == S_PRIME) || w_stream || (r_state == S_DRAIN);
  assign bus.done         = (r_state == S_DONE);
  assign bus.char_count   = r_count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= S_PRIME;
          r_ptr   <= '0;
          r_count <= '0;
        end
        // Address 0 is presented here; its data lands in the first STREAM cycle.
        S_PRIME: r_state <= S_STREAM;
        S_STREAM: if (!bus.pause) begin
          if (w_nul) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end else if (w_last) begin
            // Length limit: the final character is consumed on this edge.
            r_state <= S_DRAIN;
            r_drain <= '0;
            r_count <= r_count + 1'b1;
          end else begin
            r_ptr   <= r_ptr + 1'b1;
            r_count <= r_count + 1'b1;
          end
        end
        // Needs DRAIN_CYCLES consecutive unpaused cycles; any pause restarts it.
        S_DRAIN: begin
          if (bus.pause)                r_drain <= '0;
          else if (r_drain == DRAIN_LAST) begin
            r_state <= S_DONE;
            r_drain <= '0;
          end else                      r_drain <= r_drain + 1'b1;
        end
        S_DONE: if (w_restart) begin
          r_state <= S_PRIME;
          r_ptr   <= '0;
          r_count <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_html_char_streamer.sv
// tb_html_char_streamer
//   Two streamers: lane 0 with the full 4096-character window, lane 1 with a
//   4-character window to exercise the length limit. A document-level model
//   (expected text = ROM up to NUL or window end) is checked every negedge;
//   directed sequences pin exact timing with literal expectations.
module tb_html_char_streamer;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  html_char_streamer_if #(.ADDR_W(12), .CHAR_W(8)) bus0 ();
  html_char_streamer_if #(.ADDR_W(12), .CHAR_W(8)) bus1 ();

  html_char_streamer #(.ADDR_W(12), .CHAR_W(8), .DOC_LEN(4096), .DRAIN_CYCLES(2))
    dut0 (.clock(clock), .resetn(resetn), .bus(bus0));
  html_char_streamer #(.ADDR_W(12), .CHAR_W(8), .DOC_LEN(4), .DRAIN_CYCLES(2))
    dut1 (.clock(clock), .resetn(resetn), .bus(bus1));

  logic [7:0] rom0 [4096];
  logic [7:0] rom1 [4096];

  // Synchronous ROMs: registered address, data one cycle later.
  always @(posedge clock) begin
    bus0.mem_rdata <= rom0[bus0.mem_addr];
    bus1.mem_rdata <= rom1[bus1.mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- document-level model ----------------
  int mdl_n    [2];
  int mdl_len  [2];
  bit mdl_pdone[2];

  function automatic int lane_limit(input int lane);
    return (lane == 0) ? 4096 : 4;
  endfunction

  function automatic logic [7:0] doc_at(input int lane, input int i);
    return (lane == 0) ? rom0[i] : rom1[i];
  endfunction

  function automatic int doc_len(input int lane);
    for (int i = 0; i < lane_limit(lane); i++)
      if (doc_at(lane, i) == 8'h00) return i;
    return lane_limit(lane);
  endfunction

  task automatic model_lane(input int lane, input logic se, input logic [7:0] ch,
                            input logic [11:0] addr, input logic bsy, input logic dn,
                            input logic [12:0] cnt, input logic st, input logic fs,
                            input logic ps);
    int n;
    n = mdl_n[lane];
    if (!se)  chk("mdl_char_zero", 32'(ch), 0);
    if (!bsy) chk("mdl_addr_zero", 32'(addr), 0);
    if (se && ch != 8'h00) begin
      chk("mdl_char_seq", 32'(ch), 32'(doc_at(lane, n)));
      chk("mdl_count_run", 32'(cnt), n);
      chk("mdl_addr_run", 32'(addr), (ps || n == lane_limit(lane) - 1) ? n : n + 1);
      if (!ps) mdl_n[lane] = n + 1;
    end
    if (dn && !mdl_pdone[lane]) begin
      chk("mdl_count_done", 32'(cnt), mdl_len[lane]);
      chk("mdl_consumed", mdl_n[lane], mdl_len[lane]);
    end
    mdl_pdone[lane] = dn;
`ifdef HTML_STREAM_AUTOREPLAY_EN
    if (fs) begin mdl_n[lane] = 0; mdl_len[lane] = doc_len(lane); end
`endif
    if (st) begin mdl_n[lane] = 0; mdl_len[lane] = doc_len(lane); end
  endtask

  always @(negedge clock) begin
    if (!resetn) begin
      for (int l = 0; l < 2; l++) begin mdl_n[l] = 0; mdl_pdone[l] = 1'b0; end
    end else begin
      model_lane(0, bus0.state_enable, bus0.char, bus0.mem_addr, bus0.busy, bus0.done,
                 bus0.char_count, bus0.start, bus0.frame_start, bus0.pause);
      model_lane(1, bus1.state_enable, bus1.char, bus1.mem_addr, bus1.busy, bus1.done,
                 bus1.char_count, bus1.start, bus1.frame_start, bus1.pause);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic wait_done0(input string nm);
    int k;
    k = 0;
    while (!bus0.done && k < 40) begin cyc(); #1; k++; end
    chk(nm, 32'(bus0.done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    string s0, s1, sa;
    int pv [5];
    s0 = "<p>Hi</p>";
    s1 = "ABCDEF";
    pv = '{1, 0, 1, 0, 0};
    for (int i = 0; i < 4096; i++) begin rom0[i] = 8'h00; rom1[i] = 8'h00; end
    for (int i = 0; i < s0.len(); i++) rom0[i] = s0[i];
    for (int i = 0; i < s1.len(); i++) rom1[i] = s1[i];
    bus0.start = 0; bus0.frame_start = 0; bus0.pause = 0;
    bus1.start = 0; bus1.frame_start = 0; bus1.pause = 0;

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_se",    32'(bus0.state_enable), 0);
    chk("rst_busy",  32'(bus0.busy), 0);
    chk("rst_done",  32'(bus0.done), 0);
    chk("rst_char",  32'(bus0.char), 0);
    chk("rst_addr",  32'(bus0.mem_addr), 0);
    chk("rst_count", 32'(bus0.char_count), 0);
    resetn = 1'b1;

    // Pass 1: free-running
    cyc(); bus0.start = 1;
    cyc(); bus0.start = 0; #1;
    chk("t1_prime_busy", 32'(bus0.busy), 1);
    chk("t1_prime_se",   32'(bus0.state_enable), 0);
    for (int i = 0; i < 9; i++) begin
      cyc(); #1;
      chk("t1_char", 32'(bus0.char), 32'(s0[i]));
      chk("t1_se",   32'(bus0.state_enable), 1);
    end
    // One cycle observing the NUL, then two drain cycles.
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("t1_tail_se",   32'(bus0.state_enable), 1);
      chk("t1_tail_char", 32'(bus0.char), 0);
      chk("t1_tail_done", 32'(bus0.done), 0);
    end
    cyc(); #1;
    chk("t1_done",  32'(bus0.done), 1);
    chk("t1_se_lo", 32'(bus0.state_enable), 0);
    chk("t1_count", 32'(bus0.char_count), 9);

    // Pass 2: pause on 'H', then pause toggling in drain
    cyc(); bus0.start = 1;
    cyc(); bus0.start = 0;
    for (int i = 0; i < 3; i++) cyc();
    cyc(); bus0.pause = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_hold_char",  32'(bus0.char), 32'h48);
      chk("t2_hold_addr",  32'(bus0.mem_addr), 3);
      chk("t2_hold_count", 32'(bus0.char_count), 3);
      cyc();
    end
    bus0.pause = 0; #1;
    chk("t2_rel_char", 32'(bus0.char), 32'h48);
    chk("t2_rel_addr", 32'(bus0.mem_addr), 4);
    cyc(); #1;
    chk("t2_next_char",  32'(bus0.char), 32'h69);
    chk("t2_next_count", 32'(bus0.char_count), 4);
    for (int i = 0; i < 4; i++) cyc();
    cyc(); #1;
    chk("t2_nul_char", 32'(bus0.char), 0);
    for (int j = 0; j < 5; j++) begin
      cyc(); bus0.pause = pv[j][0]; #1;
      chk("t2_drain_done", 32'(bus0.done), 0);
      chk("t2_drain_se",   32'(bus0.state_enable), 1);
    end
    cyc(); bus0.pause = 0; #1;
    chk("t2_done",  32'(bus0.done), 1);
    chk("t2_count", 32'(bus0.char_count), 9);

    // Lane 1: 4-character window, no terminator
    sa = "ABCD";
    cyc(); bus1.start = 1;
    cyc(); bus1.start = 0; #1;
    chk("t3_prime_busy", 32'(bus1.busy), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("t3_char", 32'(bus1.char), 32'(sa[i]));
    end
    chk("t3_last_addr", 32'(bus1.mem_addr), 3);
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      chk("t3_drain_se",   32'(bus1.state_enable), 1);
      chk("t3_drain_char", 32'(bus1.char), 0);
      chk("t3_drain_done", 32'(bus1.done), 0);
    end
    cyc(); #1;
    chk("t3_done",  32'(bus1.done), 1);
    chk("t3_count", 32'(bus1.char_count), 4);

    // Reset in the middle of a pass
    cyc(); bus0.start = 1;
    cyc(); bus0.start = 0;
    for (int i = 0; i < 5; i++) cyc();
    cyc(); #1;
    chk("t5_pre_char",  32'(bus0.char), 32'h3C);
    chk("t5_pre_count", 32'(bus0.char_count), 5);
    #1 resetn = 1'b0;
    #1;
    chk("t5_rst_se",    32'(bus0.state_enable), 0);
    chk("t5_rst_busy",  32'(bus0.busy), 0);
    chk("t5_rst_char",  32'(bus0.char), 0);
    chk("t5_rst_count", 32'(bus0.char_count), 0);
    cyc(); resetn = 1'b1;
    cyc(); bus0.start = 1;
    cyc(); bus0.start = 0; #1;
    chk("t5_prime_addr", 32'(bus0.mem_addr), 0);
    cyc(); #1;
    chk("t5_first_char",  32'(bus0.char), 32'h3C);
    chk("t5_first_count", 32'(bus0.char_count), 0);
    wait_done0("t5_done");
    chk("t5_count", 32'(bus0.char_count), 9);

    // frame_start in DONE
    cyc(); bus0.frame_start = 1;
    cyc(); bus0.frame_start = 0; #1;
`ifdef HTML_STREAM_AUTOREPLAY_EN
    chk("t6_replay_done", 32'(bus0.done), 0);
    chk("t6_replay_busy", 32'(bus0.busy), 1);
    cyc(); #1;
    chk("t6_replay_char", 32'(bus0.char), 32'h3C);
    wait_done0("t6_replay_end");
`else
    chk("t6_hold_done", 32'(bus0.done), 1);
    cyc(); #1;
    chk("t6_hold_done2", 32'(bus0.done), 1);
    chk("t6_hold_char",  32'(bus0.char), 0);
`endif
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
